// File: rtl/stream_pkg.sv
// Shared types for the stream source: FSM state encoding and command bundle.
package stream_pkg;

  localparam int STREAM_DATA_W = 32;
  localparam int STREAM_CNT_W  = 16;
  localparam int STREAM_GAP_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } stream_src_state_t;

  typedef struct packed {
    logic [STREAM_DATA_W-1:0] base;
    logic [STREAM_DATA_W-1:0] step;
    logic [STREAM_CNT_W-1:0]  len;
    logic [STREAM_GAP_W-1:0]  gap;
  } stream_cmd_t;

endpackage

// File: rtl/gap_timer.sv
// Loadable down-counter with a zero flag; paces idle cycles between beats.
module gap_timer #(
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [GAP_W-1:0] cnt;

  // Load has priority over decrement; counting stops at zero.
  always_ff @(posedge clk) begin
    if (rst)                     cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - GAP_W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/stream_source.sv
// Command-to-burst stream transmitter. All outputs are registered.
// Optional inter-beat gap support is enabled by defining STREAM_SRC_GAP_EN.
module stream_source
  import stream_pkg::*;
#(
  parameter int WIDTH = STREAM_DATA_W,
  parameter int CNT_W = STREAM_CNT_W,
  parameter int GAP_W = STREAM_GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid_in,
  output logic             cmd_ready_out,
  input  logic [WIDTH-1:0] cmd_base_in,
  input  logic [WIDTH-1:0] cmd_step_in,
  input  logic [CNT_W-1:0] cmd_len_in,
  input  logic [GAP_W-1:0] cmd_gap_in,
  input  logic             ready_down_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_down_out,
  output logic             last_down_out,
  output logic             busy_out,
  output logic             done_out,
  output logic [CNT_W-1:0] beat_cnt_out
);

  stream_src_state_t state;
  logic [WIDTH-1:0]  step_q;
  logic [CNT_W-1:0]  rem_q;
  logic              cmd_fire;
  logic              down_fire;

  assign cmd_fire  = cmd_valid_in & cmd_ready_out;
  assign down_fire = valid_down_out & ready_down_in;

`ifdef STREAM_SRC_GAP_EN
  logic [GAP_W-1:0] gap_q;
  logic             gap_load;
  logic             gap_zero;

  // Timer is loaded with gap-1 so its zero flag marks the final idle cycle,
  // giving exactly gap idle cycles before the next beat.
  assign gap_load = (state == SEND) && down_fire && (rem_q != CNT_W'(1)) && (gap_q != '0);

  gap_timer #(.GAP_W(GAP_W)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (gap_q - GAP_W'(1)),
    .dec      (state == GAP),
    .zero     (gap_zero)
  );
`else
  logic unused_gap;
  assign unused_gap = ^cmd_gap_in;
`endif

  // Burst FSM with registered handshake, data accumulator and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      data_out       <= '0;
      step_q         <= '0;
      rem_q          <= '0;
      beat_cnt_out   <= '0;
      valid_down_out <= 1'b0;
      last_down_out  <= 1'b0;
      done_out       <= 1'b0;
      busy_out       <= 1'b0;
      cmd_ready_out  <= 1'b1;
`ifdef STREAM_SRC_GAP_EN
      gap_q          <= '0;
`endif
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            data_out     <= cmd_base_in;
            step_q       <= cmd_step_in;
            rem_q        <= cmd_len_in;
            beat_cnt_out <= '0;
`ifdef STREAM_SRC_GAP_EN
            gap_q        <= cmd_gap_in;
`endif
            if (cmd_len_in != '0) begin
              state          <= SEND;
              valid_down_out <= 1'b1;
              last_down_out  <= (cmd_len_in == CNT_W'(1));
              busy_out       <= 1'b1;
              cmd_ready_out  <= 1'b0;
            end else begin
              // Empty burst completes immediately without leaving IDLE.
              done_out <= 1'b1;
            end
          end
        end
        SEND: begin
          if (down_fire) begin
            beat_cnt_out <= beat_cnt_out + CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state          <= IDLE;
              valid_down_out <= 1'b0;
              last_down_out  <= 1'b0;
              busy_out       <= 1'b0;
              cmd_ready_out  <= 1'b1;
              done_out       <= 1'b1;
            end else begin
              data_out <= data_out + step_q;
              rem_q    <= rem_q - CNT_W'(1);
`ifdef STREAM_SRC_GAP_EN
              if (gap_q != '0) begin
                state          <= GAP;
                valid_down_out <= 1'b0;
                last_down_out  <= 1'b0;
              end else begin
                last_down_out  <= (rem_q == CNT_W'(2));
              end
`else
              last_down_out <= (rem_q == CNT_W'(2));
`endif
            end
          end
        end
`ifdef STREAM_SRC_GAP_EN
        GAP: begin
          if (gap_zero) begin
            state          <= SEND;
            valid_down_out <= 1'b1;
            last_down_out  <= (rem_q == CNT_W'(1));
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_source.sv
// Randomized self-checking bench for stream_source against a beat-list model.
module tb_stream_source;
  import stream_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_base = '0;
  logic [31:0] cmd_step = '0;
  logic [15:0] cmd_len = '0;
  logic [7:0]  cmd_gap = '0;
  logic        ready_down = 1'b0;
  logic [31:0] data;
  logic        valid, last, busy, done;
  logic [15:0] beat_cnt;

  // 8-bit instance for wrap-around
  logic        c8_valid = 1'b0;
  logic        c8_ready;
  logic [7:0]  c8_base = '0;
  logic [7:0]  c8_step = '0;
  logic [15:0] c8_len = '0;
  logic [7:0]  c8_gap = '0;
  logic        d8_ready = 1'b1;
  logic [7:0]  d8_data;
  logic        d8_valid, d8_last, d8_busy, d8_done;
  logic [15:0] d8_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stream_source u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready),
    .cmd_base_in(cmd_base), .cmd_step_in(cmd_step),
    .cmd_len_in(cmd_len), .cmd_gap_in(cmd_gap),
    .ready_down_in(ready_down), .data_out(data),
    .valid_down_out(valid), .last_down_out(last),
    .busy_out(busy), .done_out(done), .beat_cnt_out(beat_cnt)
  );

  stream_source #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .cmd_valid_in(c8_valid), .cmd_ready_out(c8_ready),
    .cmd_base_in(c8_base), .cmd_step_in(c8_step),
    .cmd_len_in(c8_len), .cmd_gap_in(c8_gap),
    .ready_down_in(d8_ready), .data_out(d8_data),
    .valid_down_out(d8_valid), .last_down_out(d8_last),
    .busy_out(d8_busy), .done_out(d8_done), .beat_cnt_out(d8_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one command and follow the burst: beat i carries base+i*step,
  // the last beat is i=len-1, and each accepted non-final beat is followed
  // by eg idle cycles. Ready is random (pct % high) with an optional forced
  // stall of stall_n cycles while beat stall_at is on offer.
  task automatic run_burst(input logic [31:0] base, input logic [31:0] step,
                           input logic [15:0] len, input logic [7:0] gap,
                           input int pct, input int stall_at, input int stall_n);
    int idx, gap_left, stalls, eg;
    bit exp_v, fin;
    logic [31:0] e;
`ifdef STREAM_SRC_GAP_EN
    eg = int'(gap);
`else
    eg = 0;
`endif
    @(negedge clk);
    chk("cmd_rdy_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_base = base; cmd_step = step; cmd_len = len; cmd_gap = gap;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (len == 16'd0) begin
      chk("len0_vld", valid, 1'b0);
      chk("len0_done", done, 1'b1);
      chk("len0_rdy", cmd_ready, 1'b1);
      chk("len0_cnt", beat_cnt, 16'd0);
      return;
    end
    idx = 0; gap_left = 0; stalls = stall_n; fin = 1'b0;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      exp_v = (gap_left == 0);
      chk("vld", valid, exp_v);
      chk("busy", busy, 1'b1);
      chk("cmd_rdy_busy", cmd_ready, 1'b0);
      chk("no_done", done, 1'b0);
      if (exp_v) begin
        e = base + step * 32'(idx);
        chk("data", data, e);
        chk("last", last, (idx == int'(len) - 1));
      end
      if (exp_v && idx == stall_at && stalls > 0) begin
        ready_down = 1'b0;
        stalls--;
      end else begin
        ready_down = ($urandom_range(99) < pct);
      end
      if (exp_v && ready_down) begin
        idx++;
        gap_left = eg;
      end else if (!exp_v) begin
        gap_left--;
      end
      @(negedge clk);
      if (idx == int'(len)) begin
        chk("end_done", done, 1'b1);
        chk("end_vld", valid, 1'b0);
        chk("end_busy", busy, 1'b0);
        chk("end_rdy", cmd_ready, 1'b1);
        chk("end_cnt", beat_cnt, len);
        fin = 1'b1;
      end
    end
    if (!fin) chk("timeout", 1'b0, 1'b1);
  endtask

  initial begin
    stream_cmd_t cmd;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_vld", valid, 1'b0);
    chk("rst_last", last, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", data, 32'd0);
    chk("rst_cnt", beat_cnt, 16'd0);
    chk("rst_rdy", cmd_ready, 1'b1);

    // Directed cases
    run_burst(32'h10, 32'd1, 16'd4, 8'd0, 100, -1, 0);
    run_burst(32'h10, 32'd1, 16'd4, 8'd0, 100, 1, 3);
    run_burst(32'h55, 32'd7, 16'd0, 8'd0, 100, -1, 0);
    run_burst(32'h20, 32'd3, 16'd3, 8'd2, 100, -1, 0);
    run_burst(32'hFFFF_FFFE, 32'd1, 16'd3, 8'd1, 70, -1, 0);

    // 8-bit wrap: FE, FF, 00 back to back
    @(negedge clk);
    c8_valid = 1'b1; c8_base = 8'hFE; c8_step = 8'd1; c8_len = 16'd3;
    @(negedge clk);
    c8_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("w8_vld", d8_valid, 1'b1);
      chk("w8_data", d8_data, 8'(8'hFE + i));
      chk("w8_last", d8_last, (i == 2));
      @(negedge clk);
    end
    chk("w8_done", d8_done, 1'b1);
    chk("w8_cnt", d8_cnt, 16'd3);

    // Reset after the second beat of a 5-beat burst
    @(negedge clk);
    cmd_valid = 1'b1; cmd_base = 32'h100; cmd_step = 32'd2; cmd_len = 16'd5; cmd_gap = 8'd0;
    ready_down = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mr_b0", data, 32'h100);
    @(negedge clk);
    chk("mr_b1", data, 32'h102);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_vld", valid, 1'b0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_done", done, 1'b0);
    chk("mr_rdy", cmd_ready, 1'b1);
    chk("mr_cnt", beat_cnt, 16'd0);
    run_burst(32'h300, 32'd5, 16'd2, 8'd0, 100, -1, 0);

    // Randomized bursts
    for (int n = 0; n < 20; n++) begin
      cmd.base = $urandom;
      cmd.step = $urandom;
      cmd.len  = 16'($urandom_range(6));
      cmd.gap  = 8'($urandom_range(3));
      run_burst(cmd.base, cmd.step, cmd.len, cmd.gap, int'($urandom_range(100, 40)),
                int'($urandom_range(5)), int'($urandom_range(3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
